sp_ram_fifo_ctrl: RTL and testbench

//  FIFO controller that drives our 512x8 single-port synchronous RAM (RAM_512B) as FIFO storage.

---
 rtl/sp_ram_fifo_ctrl_pkg.sv | 14 +
 rtl/RAM_512B.sv | 23 ++
 rtl/sp_ram_fifo_ctrl_skid.sv | 51 +++++
 rtl/sp_ram_fifo_ctrl.sv | 92 +++++++++
 tb/tb_sp_ram_fifo_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sp_ram_fifo_ctrl_pkg.sv
// Shared definitions for the single-port-RAM FIFO controller: port-arbitration
// op encoding and the output-buffer room test used by the read request.
package sp_ram_fifo_ctrl_pkg;

    localparam logic [0:0] OP_READ  = 1'b0;
    localparam logic [0:0] OP_WRITE = 1'b1;

    // A read may be issued only if the 2-entry buffer can absorb it together
    // with any read already on its way back from the RAM.
    function automatic logic buf_has_room(input logic [1:0] occ, input logic inflight);
        return (occ == 2'd0) || ((occ == 2'd1) && !inflight);
    endfunction

endpackage

// File: rtl/RAM_512B.sv
// 512x8 single-port synchronous RAM: write on wr_en, otherwise registered read
// of mem[addressline]; dout clears on reset, contents do not.
module RAM_512B #(
    parameter int datawidth    = 8,
    parameter int addresswidth = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [addresswidth-1:0] addressline,
    input  logic [datawidth-1:0]    din,
    output logic [datawidth-1:0]    dout
);

    logic [datawidth-1:0] mem [0:(2**addresswidth)-1];

    always_ff @(posedge clk) begin
        if (wr_en) mem[addressline] <= din;
        if (reset)       dout <= '0;
        else if (!wr_en) dout <= mem[addressline];
    end

endmodule

// File: rtl/sp_ram_fifo_ctrl_skid.sv
// Two-entry output buffer for the FIFO controller; entry 0 is always the head,
// so the downstream data stays put until it is popped.
module fifo_out_skid #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [DW-1:0] i_din,
    input  logic          i_pop,
    output logic [DW-1:0] o_dout,
    output logic          o_valid,
    output logic [1:0]    o_occ
);

    logic [DW-1:0] r_ent0;
    logic [DW-1:0] r_ent1;
    logic [1:0]    r_occ;
    logic          w_pop;

    assign w_pop = i_pop && (r_occ != 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ <= 2'd0;
        end else if (i_push && !w_pop) begin
            r_occ <= r_occ + 2'd1;
        end else if (!i_push && w_pop) begin
            r_occ <= r_occ - 2'd1;
        end
    end

    // Data entries carry no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_ent0 <= r_ent1;
            if (i_push) begin
                if (r_occ == 2'd1) r_ent0 <= i_din;
                else               r_ent1 <= i_din;
            end
        end else if (i_push) begin
            if (r_occ == 2'd0) r_ent0 <= i_din;
            else               r_ent1 <= i_din;
        end
    end

    assign o_dout  = r_ent0;
    assign o_valid = (r_occ != 2'd0);
    assign o_occ   = r_occ;

endmodule

// File: rtl/sp_ram_fifo_ctrl.sv
// FIFO controller sharing one single-port RAM between writes and reads with
// round-robin arbitration; RAM read data lands in a 2-entry output buffer.
module sp_ram_fifo_ctrl
    import sp_ram_fifo_ctrl_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          ram_wr_en,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int          DEPTH    = 2**AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_rd_inflight;
    logic [0:0]    r_last_op;

    logic          w_full;
    logic          w_wr_req;
    logic          w_rd_req;
    logic          w_wr_gnt;
    logic          w_rd_gnt;
    logic          w_pop;
    logic          w_buf_valid;
    logic [1:0]    w_occ;

    assign w_full   = (r_count == FULL_CNT);
    assign w_wr_req = !reset && s_valid && !w_full;
    assign w_rd_req = !reset && (r_count != '0) && buf_has_room(w_occ, r_rd_inflight);

    // On contention the op that did not win last time gets the port.
    assign w_wr_gnt = w_wr_req && (!w_rd_req || (r_last_op == OP_READ));
    assign w_rd_gnt = w_rd_req && !w_wr_gnt;

    assign s_ready   = w_wr_gnt;
    assign ram_wr_en = w_wr_gnt;
    assign ram_addr  = reset ? '0 : (w_wr_gnt ? r_wptr : r_rptr);
    assign ram_din   = s_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_rd_inflight <= 1'b0;
            r_last_op     <= OP_READ;
        end else begin
            if (w_wr_gnt) r_wptr <= r_wptr + AW'(1);
            if (w_rd_gnt) r_rptr <= r_rptr + AW'(1);
            r_count       <= r_count + {{AW{1'b0}}, w_wr_gnt} - {{AW{1'b0}}, w_rd_gnt};
            r_rd_inflight <= w_rd_gnt;
            if (w_wr_gnt)      r_last_op <= OP_WRITE;
            else if (w_rd_gnt) r_last_op <= OP_READ;
        end
    end

    assign w_pop = w_buf_valid && m_ready;

    fifo_out_skid #(.DW(DW)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_rd_inflight),
        .i_din   (ram_dout),
        .i_pop   (w_pop),
        .o_dout  (m_data),
        .o_valid (w_buf_valid),
        .o_occ   (w_occ)
    );

    assign m_valid = w_buf_valid;
    assign count   = r_count;
    assign full    = w_full;
    assign empty   = (r_count == '0) && !r_rd_inflight && (w_occ == 2'd0);

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Bench for sp_ram_fifo_ctrl + RAM_512B: random byte streams scored against a
// queue model of the FIFO, plus directed latency, fill, rate and reset cases.
module tb_sp_ram_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          ram_wr_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    always #5 clk = ~clk;

    sp_ram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .ram_wr_en (ram_wr_en),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    RAM_512B #(.datawidth(DW), .addresswidth(AW)) u_ram (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (ram_wr_en),
        .addressline (ram_addr),
        .din         (ram_din),
        .dout        (ram_dout)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc = 0;
    int n_pop = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: a FIFO of every accepted byte, in acceptance order.
    logic [DW-1:0] model_q [$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;

    always @(negedge clk) begin
        if (reset) begin
            model_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
            end
            chk("count_max", count > (AW+1)'(DEPTH), 0);
            chk("full_flag", full, count == (AW+1)'(DEPTH));
            chk("empty_mvalid", empty && m_valid, 0);
            if (s_valid && s_ready) begin
                model_q.push_back(s_data);
                n_acc++;
            end
            if (m_valid && m_ready) begin
                n_pop++;
                if (model_q.size() == 0) chk("pop_extra", m_valid, 0);
                else                     chk("pop_data", m_data, model_q.pop_front());
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic cycle_drive(input logic v, input logic [DW-1:0] d, input logic r);
        @(posedge clk);
        #1;
        s_valid = v;
        s_data  = d;
        m_ready = r;
        @(negedge clk);
        #1;
    endtask

    int            sent;
    int            k;
    int            pop0;
    int            acc0;
    int            first_acc;
    int            first_mv;
    int            stall;
    int            wr_cnt;
    int            rd_cnt;
    logic [DW-1:0] d;
    logic          v;
    logic          r;

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_sready", s_ready, 0);
        chk("rst_wr_en", ram_wr_en, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_empty", empty, 1);
        chk("post_rst_addr", ram_addr, 0);

        // 1: five bytes with downstream stalled, then drain; first-out latency
        first_acc = -1;
        first_mv  = -1;
        sent      = 0;
        pop0      = n_pop;
        for (int i = 0; i < 30; i++) begin
            d = 8'h05 + 8'(sent);
            cycle_drive(sent < 5, d, 1'b0);
            if (first_mv < 0 && m_valid) first_mv = cyc;
            if (s_valid && s_ready) begin
                if (first_acc < 0) first_acc = cyc;
                sent++;
            end
        end
        chk("t1_sent", sent, 5);
        chk("t1_latency", first_mv - first_acc, 3);
        chk("t1_count", count, 3);
        chk("t1_head", m_data, 8'h05);
        chk("t1_mvalid", m_valid, 1);
        for (int i = 0; i < 40; i++) cycle_drive(1'b0, 8'h00, 1'b1);
        chk("t1_pops", n_pop - pop0, 5);
        chk("t1_empty", empty, 1);

        // 2: fill with downstream stalled until writes stop, then drain
        sent  = 0;
        stall = 0;
        pop0  = n_pop;
        d     = 8'($urandom);
        for (k = 0; k < 3000 && stall < 20; k++) begin
            cycle_drive(1'b1, d, 1'b0);
            if (s_valid && s_ready) begin
                sent++;
                stall = 0;
                d = 8'($urandom);
            end else begin
                stall++;
            end
        end
        chk("t2_fill_bound", stall >= 20, 1);
        chk("t2_accepted", sent, 514);
        chk("t2_full", full, 1);
        chk("t2_count", count, 512);
        chk("t2_sready", s_ready, 0);
        for (k = 0; k < 3000 && model_q.size() > 0; k++) cycle_drive(1'b0, 8'h00, 1'b1);
        chk("t2_drain_bound", model_q.size(), 0);
        chk("t2_pops", n_pop - pop0, 514);
        repeat (4) cycle_drive(1'b0, 8'h00, 1'b1);
        chk("t2_empty", empty, 1);

        // 3: both sides always ready; measure the sustained rate mid-run
        pop0   = n_pop;
        acc0   = n_acc;
        wr_cnt = 0;
        rd_cnt = 0;
        d      = 8'($urandom);
        for (int i = 0; i < 200; i++) begin
            cycle_drive(1'b1, d, 1'b1);
            if (s_valid && s_ready) d = 8'($urandom);
            if (i >= 50 && i < 150) begin
                if (ram_wr_en) wr_cnt++;
                if (m_valid)   rd_cnt++;
            end
        end
        chk("t3_write_rate", (wr_cnt >= 45) && (wr_cnt <= 55), 1);
        chk("t3_read_rate", (rd_cnt >= 45) && (rd_cnt <= 55), 1);
        for (k = 0; k < 500 && model_q.size() > 0; k++) cycle_drive(1'b0, 8'h00, 1'b1);
        chk("t3_pops", n_pop - pop0, n_acc - acc0);

        // 4: 1000 bytes with random stalls on both sides (pointers wrap)
        sent = 0;
        pop0 = n_pop;
        d    = 8'($urandom);
        for (k = 0; k < 20000 && (sent < 1000 || model_q.size() > 0); k++) begin
            v = (sent < 1000) && ($urandom_range(99) < 70);
            r = (sent >= 1000) || ($urandom_range(99) < 60);
            cycle_drive(v, d, r);
            if (s_valid && s_ready) begin
                sent++;
                d = 8'($urandom);
            end
        end
        chk("t4_bound", k < 20000, 1);
        chk("t4_pops", n_pop - pop0, 1000);

        // 5: m_ready toggling every cycle against a full buffer
        sent = 0;
        pop0 = n_pop;
        d    = 8'($urandom);
        for (k = 0; k < 200 && sent < 20; k++) begin
            cycle_drive(1'b1, d, 1'b0);
            if (s_valid && s_ready) begin
                sent++;
                d = 8'($urandom);
            end
        end
        stall = 0;
        for (k = 0; k < 400 && model_q.size() > 0; k++) begin
            cycle_drive(1'b0, 8'h00, k[0]);
            if (m_valid && !m_ready) stall++;
        end
        chk("t5_pops", n_pop - pop0, 20);
        chk("t5_stalled", stall > 5, 1);

        // 6: reset with data resident and a read in flight
        sent = 0;
        d    = 8'($urandom);
        for (k = 0; k < 1000 && sent < 103; k++) begin
            cycle_drive(1'b1, d, 1'b0);
            if (s_valid && s_ready) begin
                sent++;
                d = 8'($urandom);
            end
        end
        repeat (5) cycle_drive(1'b0, 8'h00, 1'b0);
        chk("t6_count_pre", count, 101);
        cycle_drive(1'b0, 8'h00, 1'b1);
        cycle_drive(1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        reset   = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("t6_count_inflight", count, 100);
        chk("t6_busy", empty, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #1;
        chk("t6_mvalid", m_valid, 0);
        chk("t6_empty", empty, 1);
        chk("t6_count", count, 0);
        sent = 0;
        pop0 = n_pop;
        for (k = 0; k < 50 && sent < 2; k++) begin
            d = (sent == 0) ? 8'hA1 : 8'hA2;
            cycle_drive(1'b1, d, 1'b1);
            if (s_valid && s_ready) sent++;
        end
        for (k = 0; k < 100 && model_q.size() > 0; k++) cycle_drive(1'b0, 8'h00, 1'b1);
        repeat (10) cycle_drive(1'b0, 8'h00, 1'b1);
        chk("t6_sent", sent, 2);
        chk("t6_pops", n_pop - pop0, 2);
        chk("t6_empty_end", empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
